// File: rtl/encrypt_iterative_if.sv
// Handshake/data bundle between an AES-128 block source/sink and encrypt_iterative.
// The last_key signal exists only when ENC_LAST_KEY_OUT_EN is defined.
interface encrypt_iterative_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] plain_text;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cipher_text;
`ifdef ENC_LAST_KEY_OUT_EN
    logic [127:0] last_key;
`endif

`ifdef ENC_LAST_KEY_OUT_EN
    modport slave (
        input  in_valid, key, plain_text, out_ready,
        output in_ready, out_valid, cipher_text, last_key
    );
    modport master (
        output in_valid, key, plain_text, out_ready,
        input  in_ready, out_valid, cipher_text, last_key
    );
`else
    modport slave (
        input  in_valid, key, plain_text, out_ready,
        output in_ready, out_valid, cipher_text
    );
    modport master (
        output in_valid, key, plain_text, out_ready,
        input  in_ready, out_valid, cipher_text
    );
`endif
endinterface

// File: rtl/encrypt_iterative.sv
// AES-128 encryptor running one round per clock on a shared round datapath with on-the-fly key expansion.
// Optional feature macro ENC_LAST_KEY_OUT_EN adds a registered round-10 key output (last_key).
module encrypt_iterative (
    input  logic               clk,
    input  logic               rst_n,
    encrypt_iterative_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the block sits at bits [127-8i -: 8], with i = row + 4*column.
    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] keyExpand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h000000};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64]  ^ n0;
        n2 = rk[63:32]  ^ n1;
        n3 = rk[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       r_fsm;
    state_t       w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [7:0]   r_rcon;
    logic [3:0]   r_round;
    logic [127:0] r_cipher;
`ifdef ENC_LAST_KEY_OUT_EN
    logic [127:0] r_last_key;
`endif

    logic [127:0] w_rk_next;
    logic [127:0] w_sub_shift;
    logic [127:0] w_round_out;
    logic         w_final_round;
    logic         w_accept;
    logic         w_in_ready;
    logic         w_out_valid;

    assign w_final_round = (r_round == 4'd10);
    assign w_rk_next     = keyExpand(r_rk, r_rcon);
    assign w_sub_shift   = subShift(r_state);
    assign w_round_out   = (w_final_round ? w_sub_shift : mixColumns(w_sub_shift)) ^ w_rk_next;
    assign w_accept      = (r_fsm == IDLE) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next  = r_fsm;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_fsm)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_fsm_next = RUN;
                end
            end
            RUN: begin
                if (w_final_round) begin
                    w_fsm_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_fsm_next = IDLE;
                end
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    // The round counter saturates at 10 so the final-round edge is the only one that loads the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= '0;
            r_rk     <= '0;
            r_rcon   <= '0;
            r_round  <= '0;
            r_cipher <= '0;
`ifdef ENC_LAST_KEY_OUT_EN
            r_last_key <= '0;
`endif
        end else if (w_accept) begin
            r_state <= bus.plain_text ^ bus.key;
            r_rk    <= bus.key;
            r_rcon  <= 8'h01;
            r_round <= 4'd1;
        end else if (r_fsm == RUN) begin
            r_state <= w_round_out;
            r_rk    <= w_rk_next;
            r_rcon  <= xtime(r_rcon);
            if (w_final_round) begin
                r_cipher <= w_round_out;
`ifdef ENC_LAST_KEY_OUT_EN
                r_last_key <= w_rk_next;
`endif
            end else begin
                r_round <= r_round + 4'd1;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.cipher_text = r_cipher;
`ifdef ENC_LAST_KEY_OUT_EN
    assign bus.last_key    = r_last_key;
`endif

endmodule

// File: tb/tb_encrypt_iterative.sv
// Directed-vector bench for encrypt_iterative: FIPS-197 vectors, latency, backpressure, churn, reset and back-to-back.
// Last-key comparisons are active when ENC_LAST_KEY_OUT_EN is defined.
module tb_encrypt_iterative;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] plain;
        logic [127:0] cipher;
        logic [127:0] lastKey;
        bit           hasLk;
    } vec_t;

    logic clk;
    logic rst_n;

    encrypt_iterative_if bus();

    encrypt_iterative dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           cycle = 0;
    int           accCount = 0;
    int           accCycle[$];
    logic [127:0] outQ[$];

    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            accCount <= accCount + 1;
            accCycle.push_back(cycle);
        end
        if (bus.out_valid && bus.out_ready) begin
            outQ.push_back(bus.cipher_text);
        end
        cycle <= cycle + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] p);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 128'(bus.in_ready), 128'd1);
        bus.key        = k;
        bus.plain_text = p;
        bus.in_valid   = 1'b1;
        @(posedge clk);
    endtask

    // lat counts edges after the acceptance edge until out_valid is first seen.
    task automatic waitOut(input bit churn, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (churn) begin
                bus.in_valid   = 1'b1;
                bus.key        = rand128();
                bus.plain_text = rand128();
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid || lat >= 40) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] ct, input logic [127:0] lk,
                               input bit hasLk, input int lat, input int hold);
        check({name, "_latency"}, 128'(lat), 128'd10);
        check({name, "_cipher"}, bus.cipher_text, ct);
        check({name, "_in_ready_in_done"}, 128'(bus.in_ready), 128'd0);
`ifdef ENC_LAST_KEY_OUT_EN
        if (hasLk) check({name, "_last_key"}, bus.last_key, lk);
`else
        if (hasLk && lk === 128'hx) $display("[TB] note: last_key not built");
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_hold_valid"}, 128'(bus.out_valid), 128'd1);
            check({name, "_hold_cipher"}, bus.cipher_text, ct);
            check({name, "_hold_in_ready"}, 128'(bus.in_ready), 128'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({name, "_released_valid"}, 128'(bus.out_valid), 128'd0);
        check({name, "_released_in_ready"}, 128'(bus.in_ready), 128'd1);
    endtask

    vec_t vecs[3];

    initial begin
        int  lat;
        int  base;
        int  n;
        bit  sawValid;

        vecs[0] = '{"c1", 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
        vecs[1] = '{"b", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
        vecs[2] = '{"zero", 128'h0, 128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 1'b0};

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.key        = '0;
        bus.plain_text = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 128'(bus.in_ready), 128'd1);
        check("reset_out_valid", 128'(bus.out_valid), 128'd0);
        check("reset_cipher", bus.cipher_text, 128'd0);
`ifdef ENC_LAST_KEY_OUT_EN
        check("reset_last_key", bus.last_key, 128'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].key, vecs[i].plain);
            waitOut(1'b0, lat);
            checkOutput(vecs[i].name, vecs[i].cipher, vecs[i].lastKey, vecs[i].hasLk, lat, 0);
        end

        $display("[TB] backpressure");
        applyStimulus(vecs[0].key, vecs[0].plain);
        waitOut(1'b0, lat);
        checkOutput("bp", vecs[0].cipher, vecs[0].lastKey, 1'b1, lat, 20);

        $display("[TB] input churn");
        base = accCount;
        applyStimulus(vecs[0].key, vecs[0].plain);
        waitOut(1'b1, lat);
        checkOutput("churn", vecs[0].cipher, vecs[0].lastKey, 1'b1, lat, 0);
        repeat (3) @(negedge clk);
        check("churn_accept_count", 128'(accCount - base), 128'd1);

        $display("[TB] reset mid-run");
        applyStimulus(vecs[0].key, vecs[0].plain);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_out_valid", 128'(bus.out_valid), 128'd0);
        check("midreset_in_ready", 128'(bus.in_ready), 128'd1);
        sawValid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) sawValid = 1'b1;
        end
        check("midreset_no_partial", 128'(sawValid), 128'd0);
        applyStimulus(vecs[1].key, vecs[1].plain);
        waitOut(1'b0, lat);
        checkOutput("after_reset_b", vecs[1].cipher, vecs[1].lastKey, 1'b1, lat, 0);

        $display("[TB] valid during reset");
        rst_n          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.key        = vecs[0].key;
        bus.plain_text = vecs[0].plain;
        @(posedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        check("reset_edge_no_accept", 128'(bus.in_ready), 128'd1);
        sawValid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) sawValid = 1'b1;
        end
        check("reset_edge_stays_idle", 128'(sawValid), 128'd0);

        $display("[TB] back-to-back");
        accCycle.delete();
        outQ.delete();
        @(negedge clk);
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.key        = vecs[0].key;
        bus.plain_text = vecs[0].plain;
        n = 0;
        while (accCycle.size() < 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.key        = vecs[1].key;
        bus.plain_text = vecs[1].plain;
        n = 0;
        while (accCycle.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (outQ.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b0;
        check("b2b_accepts", 128'(accCycle.size()), 128'd2);
        check("b2b_outputs", 128'(outQ.size()), 128'd2);
        if (accCycle.size() >= 2) check("b2b_spacing", 128'(accCycle[1] - accCycle[0]), 128'd12);
        if (outQ.size() >= 1) check("b2b_first", outQ[0], vecs[0].cipher);
        if (outQ.size() >= 2) check("b2b_second", outQ[1], vecs[1].cipher);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
